// File: rtl/piezo_phase_driver_if.sv
// Avalon-MM slave bus used to program the piezo phase table and control registers.
// The master modport drives the bus and the slave modport returns registered read data.
interface piezo_phase_driver_if;
    logic [6:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/piezo_phase_driver.sv
// Phase-shifted 40 kHz square-wave generator for the transducer array.
// The shadow phase table is copied atomically into the active table at a period wrap.
module piezo_phase_driver #(
    parameter int NUM_CH  = 89,
    parameter int PERIOD  = 1250,
    parameter int PHASE_W = 11
) (
    input  logic                clk,
    input  logic                reset_n,
    piezo_phase_driver_if.slave avs,
    output logic [NUM_CH-1:0]   piezo_out,
    output logic                piezo_enable,
    output logic [2:0]          piezo_status
);

    localparam logic [6:0]         ADDR_CTRL   = 7'h7E;
    localparam logic [6:0]         ADDR_STATUS = 7'h7F;
    localparam logic [6:0]         ADDR_NCH    = 7'(NUM_CH);
    localparam logic [PHASE_W-1:0] CNT_LAST    = PHASE_W'(PERIOD - 1);
    localparam logic [PHASE_W:0]   PERIOD_X    = (PHASE_W + 1)'(PERIOD);
    localparam logic [PHASE_W:0]   HALF_X      = (PHASE_W + 1)'(PERIOD / 2);

    // High while (c - a) mod PERIOD is in the first half of the period.
    function automatic logic phase_high(input logic [PHASE_W-1:0] c,
                                        input logic [PHASE_W-1:0] a);
        logic [PHASE_W:0] d;
        if (c >= a) begin
            d = {1'b0, c} - {1'b0, a};
        end else begin
            d = {1'b0, c} + PERIOD_X - {1'b0, a};
        end
        return (d < HALF_X);
    endfunction

    logic [PHASE_W-1:0] r_cnt;
    logic [PHASE_W-1:0] r_shadow [NUM_CH];
    logic [PHASE_W-1:0] r_active [NUM_CH];
    logic               r_en_req;
    logic               r_commit_pending;
    logic               r_phase_err;
    logic               r_enable;
    logic [NUM_CH-1:0]  r_out;
    logic [31:0]        r_readdata;

    logic               w_wrap;
    logic               w_ch_wr;
    logic               w_bad_wr;
    logic               w_ctrl_wr;
    logic               w_status_wr;
    logic               w_commit_wr;
    logic               w_en_req_nxt;
    logic               w_enable_nxt;
    logic [NUM_CH-1:0]  w_hit;
    logic [31:0]        w_rd_data;

    assign w_wrap      = (r_cnt == CNT_LAST);
    assign w_ch_wr     = avs.avs_write && (avs.avs_address < ADDR_NCH);
    assign w_bad_wr    = w_ch_wr && (avs.avs_writedata >= 32'(PERIOD));
    assign w_ctrl_wr   = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    assign w_status_wr = avs.avs_write && (avs.avs_address == ADDR_STATUS);
    assign w_commit_wr = w_ctrl_wr && avs.avs_writedata[1];

    // Next enable: a drop of the request acts at once, a rise waits for the wrap.
    always_comb begin
        w_en_req_nxt = r_en_req;
        w_enable_nxt = r_enable;
        if (w_ctrl_wr) begin
            w_en_req_nxt = avs.avs_writedata[0];
        end else begin
            w_en_req_nxt = r_en_req;
        end
        if (!w_en_req_nxt) begin
            w_enable_nxt = 1'b0;
        end else if (w_wrap && r_en_req) begin
            w_enable_nxt = 1'b1;
        end else begin
            w_enable_nxt = r_enable;
        end
    end

    // Per-channel drive level for the current count and active phase.
    always_comb begin
        w_hit = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            w_hit[i] = phase_high(r_cnt, r_active[i]);
        end
    end

    // Read mux for the registered Avalon read port.
    always_comb begin
        w_rd_data = 32'd0;
        if (avs.avs_address < ADDR_NCH) begin
            w_rd_data = 32'(r_shadow[avs.avs_address]);
        end else if (avs.avs_address == ADDR_CTRL) begin
            w_rd_data = {30'd0, r_commit_pending, r_en_req};
        end else if (avs.avs_address == ADDR_STATUS) begin
            w_rd_data = {29'd0, r_phase_err, r_commit_pending, r_enable};
        end else begin
            w_rd_data = 32'd0;
        end
    end

    // Free-running period counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= {PHASE_W{1'b0}};
        end else if (w_wrap) begin
            r_cnt <= {PHASE_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + {{(PHASE_W-1){1'b0}}, 1'b1};
        end
    end

    // Shadow table writes and the atomic shadow-to-active copy at the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= {PHASE_W{1'b0}};
                r_active[i] <= {PHASE_W{1'b0}};
            end
        end else begin
            if (w_ch_wr && !w_bad_wr) begin
                r_shadow[avs.avs_address] <= avs.avs_writedata[PHASE_W-1:0];
            end
            if (w_wrap && r_commit_pending) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    // Control/status flags; a new commit request or error report wins over its clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_req         <= 1'b0;
            r_commit_pending <= 1'b0;
            r_phase_err      <= 1'b0;
            r_enable         <= 1'b0;
        end else begin
            r_en_req         <= w_en_req_nxt;
            r_commit_pending <= w_commit_wr || (r_commit_pending && !w_wrap);
            r_phase_err      <= w_bad_wr || (r_phase_err && !w_status_wr);
            r_enable         <= w_enable_nxt;
        end
    end

    // Registered drive lines and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out      <= {NUM_CH{1'b0}};
            r_readdata <= 32'd0;
        end else begin
            r_out <= w_enable_nxt ? w_hit : {NUM_CH{1'b0}};
            if (avs.avs_read) begin
                r_readdata <= w_rd_data;
            end else begin
                r_readdata <= r_readdata;
            end
        end
    end

    assign piezo_out        = r_out;
    assign piezo_enable     = r_enable;
    assign piezo_status     = {r_phase_err, r_commit_pending, r_enable};
    assign avs.avs_readdata = r_readdata;

endmodule
